// File: rtl/stack_binop_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stack_binop_if                                         |
// | Description : Request/completion and stack op/data signals between   |
// |               the decoder, stack_binop and the operand stack.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface stack_binop_if #(
  parameter int WIDTH = 8
);
  // Request side (decoder -> stack_binop)
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_imm;

  // Stack side (stack_binop <-> stack)
  logic [1:0]       stk_op;
  logic [WIDTH-1:0] stk_data;
  logic [WIDTH-1:0] stk_tos;
  logic [1:0]       stk_status;
  logic [1:0]       stk_error;

  // Completion
  logic             done;
  logic [1:0]       fault;
  logic [WIDTH-1:0] result;

  // stack_binop view
  modport master (
    input  req_valid, req_op, req_imm, stk_tos, stk_status, stk_error,
    output req_ready, stk_op, stk_data, done, fault, result
  );

  // Environment view (decoder + stack)
  modport slave (
    output req_valid, req_op, req_imm, stk_tos, stk_status, stk_error,
    input  req_ready, stk_op, stk_data, done, fault, result
  );
endinterface
`default_nettype wire

// File: rtl/stack_binop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stack_binop                                            |
// | Description : Operand-stack client. Executes CONST (push immediate)  |
// |               or a binary ALU op on the top two stack entries by     |
// |               sequencing PUSH/POP/REPLACE, then pulses done with a   |
// |               fault code and the written result.                     |
// | Options     : STACK_BINOP_RESTORE_EN - on underflow after the POP,   |
// |               push b back so the stack keeps its prior contents.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module stack_binop #(
  parameter int WIDTH = 8
) (
  input  wire logic    clk,
  input  wire logic    reset,    // asynchronous, active-low
  stack_binop_if.master io_bus
);

  // Stack op codes
  localparam logic [1:0] C_OP_NONE    = 2'd0;
  localparam logic [1:0] C_OP_PUSH    = 2'd1;
  localparam logic [1:0] C_OP_POP     = 2'd2;
  localparam logic [1:0] C_OP_REPLACE = 2'd3;
  // Stack status codes
  localparam logic [1:0] C_ST_EMPTY   = 2'd1;
  localparam logic [1:0] C_ST_FULL    = 2'd2;
  // Error / fault codes
  localparam logic [1:0] C_ERR_NONE      = 2'd0;
  localparam logic [1:0] C_ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] C_ERR_OVERFLOW  = 2'd2;
  // Request op codes
  localparam logic [2:0] C_REQ_CONST = 3'd0;
  localparam logic [2:0] C_REQ_ADD   = 3'd1;
  localparam logic [2:0] C_REQ_SUB   = 3'd2;
  localparam logic [2:0] C_REQ_AND   = 3'd3;
  localparam logic [2:0] C_REQ_OR    = 3'd4;
  localparam logic [2:0] C_REQ_XOR   = 3'd5;
  localparam logic [2:0] C_REQ_EQ    = 3'd6;
  localparam logic [2:0] C_REQ_LTU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POPB = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_fault;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_b_load;
  logic             w_fault_load;
  logic [1:0]       w_fault_val;
  logic             w_res_load;
  logic [WIDTH-1:0] w_res_val;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_a;

  // After the POP, the new top of stack is operand a.
  assign w_a = io_bus.stk_tos;

  // ALU: f(a, b) modulo 2^WIDTH; compares yield a zero-extended 0/1.
  always_comb begin
    w_alu = '0;
    case (r_op)
      C_REQ_ADD: w_alu = w_a + r_b;
      C_REQ_SUB: w_alu = w_a - r_b;
      C_REQ_AND: w_alu = w_a & r_b;
      C_REQ_OR:  w_alu = w_a | r_b;
      C_REQ_XOR: w_alu = w_a ^ r_b;
      C_REQ_EQ:  w_alu = {{(WIDTH-1){1'b0}}, (w_a == r_b)};
      C_REQ_LTU: w_alu = {{(WIDTH-1){1'b0}}, (w_a < r_b)};
      default:   w_alu = '0;
    endcase
  end

  // Next-state, state-decoded outputs and register load enables.
  always_comb begin
    w_next           = r_state;
    w_accept         = 1'b0;
    w_b_load         = 1'b0;
    w_fault_load     = 1'b0;
    w_fault_val      = r_fault;
    w_res_load       = 1'b0;
    w_res_val        = r_result;
    io_bus.req_ready = 1'b0;
    io_bus.stk_op    = C_OP_NONE;
    io_bus.stk_data  = '0;
    io_bus.done      = 1'b0;
    io_bus.fault     = C_ERR_NONE;

    case (r_state)
      S_IDLE: begin
        io_bus.req_ready = 1'b1;
        if (io_bus.req_valid) begin
          w_accept     = 1'b1;
          w_fault_load = 1'b1;
          w_fault_val  = C_ERR_NONE;
          w_next       = (io_bus.req_op == C_REQ_CONST) ? S_PUSH : S_POPB;
        end
      end

      S_PUSH: begin
        if (io_bus.stk_status == C_ST_FULL) begin
          w_fault_load = 1'b1;
          w_fault_val  = C_ERR_OVERFLOW;
        end else begin
          io_bus.stk_op   = C_OP_PUSH;
          io_bus.stk_data = r_imm;
          w_res_load      = 1'b1;
          w_res_val       = r_imm;
        end
        w_next = S_DONE;
      end

      S_POPB: begin
        if (io_bus.stk_status == C_ST_EMPTY) begin
          w_fault_load = 1'b1;
          w_fault_val  = C_ERR_UNDERFLOW;
          w_next       = S_DONE;
        end else begin
          w_b_load      = 1'b1;
          io_bus.stk_op = C_OP_POP;
          w_next        = S_EXEC;
        end
      end

      S_EXEC: begin
        if (io_bus.stk_status == C_ST_EMPTY) begin
          w_fault_load = 1'b1;
          w_fault_val  = C_ERR_UNDERFLOW;
`ifdef STACK_BINOP_RESTORE_EN
          // Put b back so the stack looks untouched by this request.
          io_bus.stk_op   = C_OP_PUSH;
          io_bus.stk_data = r_b;
`else
          // b is dropped; the stack is left empty.
          io_bus.stk_op   = C_OP_NONE;
`endif
        end else begin
          io_bus.stk_op   = C_OP_REPLACE;
          io_bus.stk_data = w_alu;
          w_res_load      = 1'b1;
          w_res_val       = w_alu;
        end
        w_next = S_DONE;
      end

      S_DONE: begin
        io_bus.done = 1'b1;
        // A fault latched earlier wins over anything the stack reports.
        io_bus.fault = (r_fault != C_ERR_NONE) ? r_fault : io_bus.stk_error;
        w_next       = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

  assign io_bus.result = r_result;

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_imm    <= '0;
      r_b      <= '0;
      r_fault  <= C_ERR_NONE;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= io_bus.req_op;
        r_imm <= io_bus.req_imm;
      end
      if (w_b_load)     r_b      <= io_bus.stk_tos;
      if (w_fault_load) r_fault  <= w_fault_val;
      if (w_res_load)   r_result <= w_res_val;
    end
  end

endmodule
`default_nettype wire
